// File: rtl/ir_packet_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : ir_packet_tx_if
// Purpose  : Request/status bundle between the command logic and the IR
//            packet transmitter.
// Signals  : i_send_packet  request pulse toward the transmitter
//            i_command      command bits, captured when a request is taken
//            i_repeat_en    enables periodic retransmission
//            o_ir_led       modulated LED drive
//            o_busy         packet in flight
//            o_packet_done  one-cycle end-of-packet pulse
//            o_state        IDLE=0 START=1 GAP=2 SELECT=3 ASSERT=4 DEASSERT=5
//            o_bit_index    command bits completed in the current packet
// Modports : slave  - transmitter side
//            master - requester side
// Revision : 1.0  initial release
// ============================================================================
interface ir_packet_tx_if #(
  parameter int N_CMD_BITS = 4
);
  localparam int c_IDX_W = $clog2(N_CMD_BITS + 1);

  logic                  i_send_packet;
  logic [N_CMD_BITS-1:0] i_command;
  logic                  i_repeat_en;
  logic                  o_ir_led;
  logic                  o_busy;
  logic                  o_packet_done;
  logic [2:0]            o_state;
  logic [c_IDX_W-1:0]    o_bit_index;

  modport slave (
    input  i_send_packet, i_command, i_repeat_en,
    output o_ir_led, o_busy, o_packet_done, o_state, o_bit_index
  );

  modport master (
    output i_send_packet, i_command, i_repeat_en,
    input  o_ir_led, o_busy, o_packet_done, o_state, o_bit_index
  );
endinterface
`default_nettype wire

// File: rtl/ir_packet_tx.sv
`default_nettype none
// ============================================================================
// Module   : ir_packet_tx
// Purpose  : IR remote-control packet generator. Emits START burst, GAP,
//            SELECT burst, GAP, then per command bit (MSB first) an ASSERT
//            or DEASSERT burst followed by a GAP. Supports one pending
//            request and an optional auto-repeat timer.
// Ports    : clk    system clock, rising edge
//            rst_n  synchronous reset, active low
//            bus    ir_packet_tx_if.slave (request, command, LED, status)
// Revision : 1.0  initial release
// ============================================================================
module ir_packet_tx #(
  parameter int N_CMD_BITS     = 4,
  parameter int CARRIER_HALF   = 1389,
  parameter int START_BURST    = 192,
  parameter int GAP_SIZE       = 24,
  parameter int SELECT_BURST   = 24,
  parameter int ASSERT_BURST   = 48,
  parameter int DEASSERT_BURST = 24,
  parameter int REPEAT_PERIOD  = 10_000_000
) (
  input  logic          clk,
  input  logic          rst_n,
  ir_packet_tx_if.slave bus
);

  localparam int c_IDX_W = $clog2(N_CMD_BITS + 1);

  // Terminal counts (length - 1) for each phase, in clocks.
  localparam logic [31:0] c_START_LAST = 32'(2 * START_BURST    * CARRIER_HALF - 1);
  localparam logic [31:0] c_GAP_LAST   = 32'(2 * GAP_SIZE       * CARRIER_HALF - 1);
  localparam logic [31:0] c_SEL_LAST   = 32'(2 * SELECT_BURST   * CARRIER_HALF - 1);
  localparam logic [31:0] c_ASRT_LAST  = 32'(2 * ASSERT_BURST   * CARRIER_HALF - 1);
  localparam logic [31:0] c_DASR_LAST  = 32'(2 * DEASSERT_BURST * CARRIER_HALF - 1);
  localparam logic [31:0] c_HALF_LAST  = 32'(CARRIER_HALF - 1);
  localparam logic [31:0] c_REP_LAST   = 32'(REPEAT_PERIOD - 1);
  localparam logic [c_IDX_W-1:0] c_NBITS = c_IDX_W'(N_CMD_BITS);
  localparam bit          c_REP_ON     = (REPEAT_PERIOD > 0);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_GAP      = 3'd2,
    S_SELECT   = 3'd3,
    S_ASSERT   = 3'd4,
    S_DEASSERT = 3'd5
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [31:0]           r_phase_cnt, r_car_cnt, r_rep_tmr;
  logic [31:0]           w_last_cnt, w_tmr_nxt;
  logic [N_CMD_BITS-1:0] r_shift, r_cmd, r_pend_cmd, w_start_cmd;
  logic [c_IDX_W-1:0]    r_bit_idx;
  logic                  r_pend, r_rep_due, r_sel_done, r_led, r_busy, r_done;
  logic                  w_phase_end, w_pkt_start, w_pkt_end, w_bit_done;
  logic                  w_start_req, w_rep_req, w_phase_chg, w_burst_nxt;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and control strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_pkt_start = 1'b0;
    w_pkt_end   = 1'b0;
    w_bit_done  = 1'b0;
    w_last_cnt  = c_GAP_LAST;

    // A fresh request beats a pending one, which beats a repeat.
    w_rep_req   = r_rep_due && bus.i_repeat_en;
    w_start_req = bus.i_send_packet || r_pend || w_rep_req;
    if (bus.i_send_packet) begin
      w_start_cmd = bus.i_command;
    end else if (r_pend) begin
      w_start_cmd = r_pend_cmd;
    end else begin
      w_start_cmd = r_cmd;
    end

    case (r_state)
      S_START:    w_last_cnt = c_START_LAST;
      S_SELECT:   w_last_cnt = c_SEL_LAST;
      S_ASSERT:   w_last_cnt = c_ASRT_LAST;
      S_DEASSERT: w_last_cnt = c_DASR_LAST;
      default:    w_last_cnt = c_GAP_LAST;
    endcase
    w_phase_end = (r_phase_cnt == w_last_cnt);

    case (r_state)
      S_IDLE: begin
        if (w_start_req) begin
          w_state_nxt = S_START;
          w_pkt_start = 1'b1;
        end
      end
      S_START, S_SELECT: begin
        if (w_phase_end) w_state_nxt = S_GAP;
      end
      S_ASSERT, S_DEASSERT: begin
        if (w_phase_end) begin
          w_state_nxt = S_GAP;
          w_bit_done  = 1'b1;
        end
      end
      S_GAP: begin
        if (w_phase_end) begin
          if (!r_sel_done) begin
            w_state_nxt = S_SELECT;
          end else if (r_bit_idx < c_NBITS) begin
            w_state_nxt = r_shift[N_CMD_BITS-1] ? S_ASSERT : S_DEASSERT;
          end else begin
            // Packet end; a queued request chains straight into START.
            w_pkt_end = 1'b1;
            if (w_start_req) begin
              w_state_nxt = S_START;
              w_pkt_start = 1'b1;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_phase_chg = w_pkt_start || (w_state_nxt != r_state);
    w_burst_nxt = (w_state_nxt == S_START)  || (w_state_nxt == S_SELECT) ||
                  (w_state_nxt == S_ASSERT) || (w_state_nxt == S_DEASSERT);

    if (w_pkt_start || (r_rep_tmr == c_REP_LAST)) begin
      w_tmr_nxt = '0;
    end else begin
      w_tmr_nxt = r_rep_tmr + 32'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath: phase/carrier counters, command shift, pending, repeat
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_phase_cnt <= '0;
      r_car_cnt   <= '0;
      r_led       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_shift     <= '0;
      r_cmd       <= '0;
      r_pend_cmd  <= '0;
      r_pend      <= 1'b0;
      r_sel_done  <= 1'b0;
      r_bit_idx   <= '0;
      r_rep_tmr   <= '0;
      r_rep_due   <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= w_pkt_end;

      if (w_phase_chg) begin
        r_phase_cnt <= '0;
      end else if (r_state != S_IDLE) begin
        r_phase_cnt <= r_phase_cnt + 32'd1;
      end

      // Carrier: LED high for the first half-period of every burst entry.
      if (w_burst_nxt) begin
        if (w_phase_chg) begin
          r_car_cnt <= '0;
          r_led     <= 1'b1;
        end else if (r_car_cnt == c_HALF_LAST) begin
          r_car_cnt <= '0;
          r_led     <= ~r_led;
        end else begin
          r_car_cnt <= r_car_cnt + 32'd1;
        end
      end else begin
        r_car_cnt <= '0;
        r_led     <= 1'b0;
      end

      if (w_pkt_start) begin
        r_shift    <= w_start_cmd;
        r_cmd      <= w_start_cmd;
        r_bit_idx  <= '0;
        r_sel_done <= 1'b0;
      end else begin
        if (w_bit_done) begin
          r_shift   <= r_shift << 1;
          r_bit_idx <= r_bit_idx + 1'b1;
        end
        if (r_state == S_SELECT && w_phase_chg) r_sel_done <= 1'b1;
      end

      if (w_pkt_start) begin
        r_pend <= 1'b0;
      end else if (bus.i_send_packet && r_busy) begin
        r_pend     <= 1'b1;
        r_pend_cmd <= bus.i_command;
      end

      if (!c_REP_ON || !bus.i_repeat_en) begin
        r_rep_tmr <= '0;
        r_rep_due <= 1'b0;
      end else begin
        r_rep_tmr <= w_tmr_nxt;
        if (w_tmr_nxt == c_REP_LAST) begin
          r_rep_due <= 1'b1;
        end else if (w_pkt_start) begin
          r_rep_due <= 1'b0;
        end
      end
    end
  end

  assign bus.o_ir_led      = r_led;
  assign bus.o_busy        = r_busy;
  assign bus.o_packet_done = r_done;
  assign bus.o_state       = r_state;
  assign bus.o_bit_index   = r_bit_idx;

endmodule
`default_nettype wire

// File: tb/tb_ir_packet_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ir_packet_tx
// Purpose  : Self-checking bench for ir_packet_tx with small phase sizes.
//            A 4-bit instance covers single, chained, repeat and reset
//            scenarios; an 8-bit instance covers a wide command.
// Revision : 1.0  initial release
// ============================================================================
module tb_ir_packet_tx;
  localparam int P_CH    = 2;
  localparam int P_START = 4;
  localparam int P_GAP   = 2;
  localparam int P_SEL   = 2;
  localparam int P_AS    = 3;
  localparam int P_DE    = 1;
  localparam int P_REP   = 150;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  ir_packet_tx_if #(.N_CMD_BITS(4)) b4 ();
  ir_packet_tx_if #(.N_CMD_BITS(8)) b8 ();

  ir_packet_tx #(
    .N_CMD_BITS(4), .CARRIER_HALF(P_CH), .START_BURST(P_START), .GAP_SIZE(P_GAP),
    .SELECT_BURST(P_SEL), .ASSERT_BURST(P_AS), .DEASSERT_BURST(P_DE), .REPEAT_PERIOD(P_REP)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(b4.slave));

  ir_packet_tx #(
    .N_CMD_BITS(8), .CARRIER_HALF(P_CH), .START_BURST(P_START), .GAP_SIZE(P_GAP),
    .SELECT_BURST(P_SEL), .ASSERT_BURST(P_AS), .DEASSERT_BURST(P_DE), .REPEAT_PERIOD(0)
  ) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: packet as a list of (phase code, length); returns {led, state}
  // expected t clocks after the packet start edge, IDLE past the end.
  function automatic logic [3:0] model(input logic [7:0] cmd, input int nbits, input int t);
    int code[$];
    int len[$];
    int acc;
    logic [2:0] s;
    logic led;
    code.push_back(1); len.push_back(2 * P_START * P_CH);
    code.push_back(2); len.push_back(2 * P_GAP * P_CH);
    code.push_back(3); len.push_back(2 * P_SEL * P_CH);
    code.push_back(2); len.push_back(2 * P_GAP * P_CH);
    for (int b = nbits - 1; b >= 0; b--) begin
      code.push_back(cmd[b] ? 4 : 5);
      len.push_back(2 * (cmd[b] ? P_AS : P_DE) * P_CH);
      code.push_back(2); len.push_back(2 * P_GAP * P_CH);
    end
    acc = 0;
    foreach (code[i]) begin
      if (t < acc + len[i]) begin
        s   = 3'(code[i]);
        led = (code[i] != 2) && ((((t - acc) / P_CH) % 2) == 0);
        return {led, s};
      end
      acc += len[i];
    end
    return 4'b0000;
  endfunction

  function automatic int pkt_len(input logic [7:0] cmd, input int nbits);
    int n;
    n = 2 * P_CH * (P_START + P_GAP + P_SEL + P_GAP);
    for (int b = 0; b < nbits; b++) n += 2 * P_CH * ((cmd[b] ? P_AS : P_DE) + P_GAP);
    return n;
  endfunction

  // Follows one packet from its start edge (already sampled) to its end edge,
  // tallying disagreements with the model; optionally injects requests on b4
  // (sampled at edges inj_a / inj_b) and drops repeat enable at edge drop_t.
  task automatic run_trace(input bit wide, input logic [7:0] cmd, input int nbits,
                           input int inj_a, input logic [3:0] cmd_a,
                           input int inj_b, input logic [3:0] cmd_b, input int drop_t,
                           output int errs, output string info);
    int len;
    logic [3:0] ex;
    logic [2:0] st;
    logic led, busy, done;
    len  = pkt_len(cmd, nbits);
    errs = 0;
    info = "none";
    for (int t = 0; t < len; t++) begin
      st   = wide ? b8.o_state       : b4.o_state;
      led  = wide ? b8.o_ir_led      : b4.o_ir_led;
      busy = wide ? b8.o_busy        : b4.o_busy;
      done = wide ? b8.o_packet_done : b4.o_packet_done;
      ex   = model(cmd, nbits, t);
      if (st !== ex[2:0] || led !== ex[3] || busy !== 1'b1 || (t > 0 && done !== 1'b0)) begin
        if (errs == 0)
          info = $sformatf("t=%0d state=%0d want %0d led=%b want %b busy=%b done=%b",
                           t, st, ex[2:0], led, ex[3], busy, done);
        errs++;
      end
      if (t == inj_a - 1) begin
        b4.i_send_packet = 1'b1; b4.i_command = cmd_a;
      end else if (t == inj_b - 1) begin
        b4.i_send_packet = 1'b1; b4.i_command = cmd_b;
      end else begin
        b4.i_send_packet = 1'b0;
      end
      if (t == drop_t - 1) b4.i_repeat_en = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    b4.i_send_packet = 1'b0; b4.i_command = '0; b4.i_repeat_en = 1'b0;
    b8.i_send_packet = 1'b0; b8.i_command = '0; b8.i_repeat_en = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (b4.o_state !== 3'd0) $display("FAIL reset_state: got %0d want 0", b4.o_state); else n_pass++;
    n_checks++;
    if (b4.o_ir_led !== 1'b0) $display("FAIL reset_led: got %b want 0", b4.o_ir_led); else n_pass++;
    n_checks++;
    if (b4.o_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", b4.o_busy); else n_pass++;
    n_checks++;
    if (b4.o_packet_done !== 1'b0) $display("FAIL reset_done: got %b want 0", b4.o_packet_done); else n_pass++;
    n_checks++;
    if (b4.o_bit_index !== 3'd0) $display("FAIL reset_bitidx: got %0d want 0", b4.o_bit_index); else n_pass++;
    n_checks++;
    if (b8.o_state !== 3'd0 || b8.o_busy !== 1'b0)
      $display("FAIL reset_wide: state %0d busy %b want 0 0", b8.o_state, b8.o_busy); else n_pass++;
    rst_n = 1'b1;
    repeat (2) tick();
    n_checks++;
    if (b4.o_state !== 3'd0 || b4.o_busy !== 1'b0)
      $display("FAIL reset_release_idle: state %0d busy %b want 0 0", b4.o_state, b4.o_busy); else n_pass++;
  endtask

  task automatic test_single(input logic [3:0] cmd);
    int errs;
    string info;
    b4.i_command = cmd; b4.i_send_packet = 1'b1;
    tick();
    run_trace(1'b0, {4'h0, cmd}, 4, -1, 4'h0, -1, 4'h0, -1, errs, info);
    n_checks++;
    if (errs !== 0) $display("FAIL single_trace cmd=%b: %0d bad cycles, first %s", cmd, errs, info); else n_pass++;
    n_checks++;
    if (b4.o_state !== 3'd0 || b4.o_busy !== 1'b0 || b4.o_packet_done !== 1'b1 || b4.o_bit_index !== 3'd4)
      $display("FAIL single_end cmd=%b: state %0d busy %b done %b idx %0d want 0 0 1 4",
               cmd, b4.o_state, b4.o_busy, b4.o_packet_done, b4.o_bit_index);
    else n_pass++;
    tick();
    n_checks++;
    if (b4.o_packet_done !== 1'b0 || b4.o_ir_led !== 1'b0)
      $display("FAIL single_done_pulse: done %b led %b want 0 0", b4.o_packet_done, b4.o_ir_led); else n_pass++;
  endtask

  task automatic test_back_to_back(input logic [3:0] c1, input int ta, input logic [3:0] ca,
                                   input int tb, input logic [3:0] cb);
    int errs;
    string info;
    b4.i_command = c1; b4.i_send_packet = 1'b1;
    tick();
    run_trace(1'b0, {4'h0, c1}, 4, ta, ca, tb, cb, -1, errs, info);
    n_checks++;
    if (errs !== 0) $display("FAIL b2b_first_trace: %0d bad cycles, first %s", errs, info); else n_pass++;
    n_checks++;
    if (b4.o_packet_done !== 1'b1 || b4.o_state !== 3'd1 || b4.o_busy !== 1'b1)
      $display("FAIL b2b_handover: done %b state %0d busy %b want 1 1 1",
               b4.o_packet_done, b4.o_state, b4.o_busy);
    else n_pass++;
    // The most recent request wins.
    run_trace(1'b0, {4'h0, (tb > 0) ? cb : ca}, 4, -1, 4'h0, -1, 4'h0, -1, errs, info);
    n_checks++;
    if (errs !== 0) $display("FAIL b2b_second_trace: %0d bad cycles, first %s", errs, info); else n_pass++;
    n_checks++;
    if (b4.o_packet_done !== 1'b1 || b4.o_state !== 3'd0)
      $display("FAIL b2b_end: done %b state %0d want 1 0", b4.o_packet_done, b4.o_state); else n_pass++;
    tick();
  endtask

  task automatic test_idle_restart();
    int errs;
    string info;
    logic [3:0] c1, c2;
    c1 = 4'($urandom); c2 = 4'($urandom);
    b4.i_command = c1; b4.i_send_packet = 1'b1;
    tick();
    run_trace(1'b0, {4'h0, c1}, 4, -1, 4'h0, -1, 4'h0, -1, errs, info);
    b4.i_command = c2; b4.i_send_packet = 1'b1;
    tick();
    n_checks++;
    if (b4.o_state !== 3'd1 || b4.o_busy !== 1'b1 || b4.o_packet_done !== 1'b0)
      $display("FAIL idle_restart_start: state %0d busy %b done %b want 1 1 0",
               b4.o_state, b4.o_busy, b4.o_packet_done);
    else n_pass++;
    run_trace(1'b0, {4'h0, c2}, 4, -1, 4'h0, -1, 4'h0, -1, errs, info);
    n_checks++;
    if (errs !== 0) $display("FAIL idle_restart_trace: %0d bad cycles, first %s", errs, info); else n_pass++;
    tick();
  endtask

  task automatic test_repeat();
    int errs, len, busy_cycles;
    string info;
    logic [3:0] c;
    c   = 4'($urandom);
    len = pkt_len({4'h0, c}, 4);
    b4.i_repeat_en = 1'b1; b4.i_command = c; b4.i_send_packet = 1'b1;
    tick();
    run_trace(1'b0, {4'h0, c}, 4, -1, 4'h0, -1, 4'h0, -1, errs, info);
    n_checks++;
    if (errs !== 0) $display("FAIL repeat_first_trace: %0d bad cycles, first %s", errs, info); else n_pass++;
    b4.i_command = ~c;
    errs = 0;
    for (int t = len; t < P_REP; t++) begin
      if (b4.o_state !== 3'd0 || b4.o_busy !== 1'b0) errs++;
      tick();
    end
    n_checks++;
    if (errs !== 0) $display("FAIL repeat_idle_gap: %0d non-idle cycles before edge %0d want 0", errs, P_REP); else n_pass++;
    n_checks++;
    if (b4.o_state !== 3'd1 || b4.o_busy !== 1'b1)
      $display("FAIL repeat_restart: state %0d busy %b want 1 1", b4.o_state, b4.o_busy); else n_pass++;
    run_trace(1'b0, {4'h0, c}, 4, -1, 4'h0, -1, 4'h0, 10, errs, info);
    n_checks++;
    if (errs !== 0) $display("FAIL repeat_second_trace: %0d bad cycles, first %s", errs, info); else n_pass++;
    busy_cycles = 0;
    for (int t = 0; t < 2 * P_REP; t++) begin
      tick();
      if (b4.o_busy !== 1'b0 || b4.o_state !== 3'd0) busy_cycles++;
    end
    n_checks++;
    if (busy_cycles !== 0) $display("FAIL repeat_disabled: %0d busy cycles want 0", busy_cycles); else n_pass++;
  endtask

  task automatic test_reset_mid(input int rst_t);
    int errs;
    logic [3:0] c;
    c = 4'($urandom);
    b4.i_command = c; b4.i_send_packet = 1'b1;
    tick();
    for (int t = 0; t < rst_t; t++) begin
      b4.i_send_packet = (t == 19);
      if (t == 19) b4.i_command = ~c;
      if (t == rst_t - 1) rst_n = 1'b0;
      tick();
    end
    n_checks++;
    if (b4.o_state !== 3'd0 || b4.o_ir_led !== 1'b0)
      $display("FAIL rstmid_state_led at %0d: state %0d led %b want 0 0", rst_t, b4.o_state, b4.o_ir_led); else n_pass++;
    n_checks++;
    if (b4.o_busy !== 1'b0 || b4.o_packet_done !== 1'b0)
      $display("FAIL rstmid_busy_done at %0d: busy %b done %b want 0 0", rst_t, b4.o_busy, b4.o_packet_done); else n_pass++;
    rst_n = 1'b1;
    errs = 0;
    for (int t = 0; t < 200; t++) begin
      tick();
      if (b4.o_state !== 3'd0 || b4.o_busy !== 1'b0 || b4.o_packet_done !== 1'b0) errs++;
    end
    n_checks++;
    if (errs !== 0) $display("FAIL rstmid_pending_dropped: %0d active cycles want 0", errs); else n_pass++;
  endtask

  task automatic test_wide(input logic [7:0] c);
    int errs;
    string info;
    b8.i_command = c; b8.i_send_packet = 1'b1;
    tick();
    b8.i_send_packet = 1'b0;
    run_trace(1'b1, c, 8, -1, 4'h0, -1, 4'h0, -1, errs, info);
    n_checks++;
    if (errs !== 0) $display("FAIL wide_trace cmd=%h: %0d bad cycles, first %s", c, errs, info); else n_pass++;
    n_checks++;
    if (b8.o_bit_index !== 4'd8 || b8.o_packet_done !== 1'b1 || b8.o_state !== 3'd0)
      $display("FAIL wide_end cmd=%h: idx %0d done %b state %0d want 8 1 0",
               c, b8.o_bit_index, b8.o_packet_done, b8.o_state);
    else n_pass++;
    tick();
  endtask

  initial begin
    test_reset();
    test_single(4'b1010);
    for (int i = 0; i < 3; i++) test_single(4'($urandom));
    test_back_to_back(4'b1010, 50, 4'b0001, -1, 4'h0);
    test_back_to_back(4'($urandom), 50, 4'($urandom), 70, 4'($urandom));
    test_idle_restart();
    test_repeat();
    test_reset_mid(30);
    test_reset_mid(28);
    test_wide(8'hFF);
    test_wide(8'($urandom));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
